// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage: instruction-fetch stage of a 5-stage RISC-V pipeline.
//   Holds the PC, selects the next PC, drives the instruction-memory address
//   and owns the IF/ID pipeline register. It also counts cycles spent in a
//   load-use stall.
//
// Optional feature (compile-time macro JUMP_IN_FETCH_EN):
//   When the macro is defined, JAL is resolved in fetch: the PC jumps straight
//   to pc + J-imm and jump_taken_if pulses for that cycle.
//   When it is undefined, JAL follows the pc+4 path and EX redirects it later.
//
// Parameters:
//   RESET_PC   PC value loaded on reset
//   NOP_INSTR  bubble instruction placed in IF/ID on flush/reset
//   CNT_W      width of the stall-cycle counter
//
// Ports:
//   clk, arst_n      clock (rising edge); asynchronous active-low reset
//   pc_write         1 = PC may advance, 0 = hold PC
//   if_id_write      1 = IF/ID may load, 0 = hold IF/ID
//   redirect_valid   taken branch/jump resolved in EX this cycle
//   redirect_target  PC to redirect to (low two bits are ignored)
//   imem_addr        instruction memory address (combinational, equal to PC)
//   imem_rdata       instruction word, read combinationally from imem_addr
//   if_id_pc         PC of the instruction held in IF/ID
//   if_id_instr      instruction held in IF/ID
//   if_id_valid      1 = IF/ID holds a real instruction, 0 = bubble
//   jump_taken_if    JAL redirected in fetch this cycle (combinational)
//   stall_cnt        saturating count of cycles with pc_write=0
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             pc_write,
    input  logic             if_id_write,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_instr,
    output logic             if_id_valid,
    output logic             jump_taken_if,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned XLEN       = 32;
    localparam logic [6:0]  OPCODE_JAL = 7'b1101111;

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0]  if_id_instr_q, if_id_instr_d;
    logic             if_id_valid_q, if_id_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic             jump_c;
    logic [XLEN-1:0]  jal_imm_c;

    // JAL detection in fetch. It is only taken when the PC is free to move and
    // EX is not redirecting.
`ifdef JUMP_IN_FETCH_EN
    always_comb begin
        jal_imm_c = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                     imem_rdata[20], imem_rdata[30:21], 1'b0};
        jump_c    = pc_write && !redirect_valid && (imem_rdata[6:0] == OPCODE_JAL);
    end
`else
    always_comb begin
        jal_imm_c = '0;
        jump_c    = 1'b0;
    end
`endif

    // Next PC: redirect > hold > JAL-in-fetch > sequential.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_target[XLEN-1:2], 2'b00};
        end else if (!pc_write) begin
            pc_d = pc_q;
        end else if (jump_c) begin
            pc_d = pc_q + jal_imm_c;
        end else begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    // IF/ID: a flush beats the hold, because the held instruction is on the wrong path.
    always_comb begin
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (redirect_valid) begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (if_id_write) begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem_rdata;
            if_id_valid_d = 1'b1;
        end
    end

    // Saturating stall counter. It counts every pc_write=0 cycle, redirect or not.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign imem_addr     = pc_q;
    assign if_id_pc      = if_id_pc_q;
    assign if_id_instr   = if_id_instr_q;
    assign if_id_valid   = if_id_valid_q;
    assign stall_cnt     = stall_cnt_q;
    assign jump_taken_if = jump_c;

endmodule
